// File: rtl/mux_rr_arb.sv
// Round-robin source arbiter driving a shared mux, with a one-entry registered output stage.
// Latency: a word granted in cycle N is on out_data in N+1. A full stage with out_ready low blocks all grants.
module mux_rr_arb #(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 2,
    parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DEPTH-1:0]     req_valid,
    output logic [DEPTH-1:0]     req_ready,
    output logic [SEL_WIDTH-1:0] mux_sel,
    output logic                 mux_en_n,
    input  logic [BIT_WIDTH-1:0] mux_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [SEL_WIDTH-1:0] out_src
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0]   src_q, src_d;
    logic [BIT_WIDTH-1:0]   data_q, data_d;
    logic [SEL_WIDTH-1:0]   winner;
    logic                   found;
    logic                   can_load;
    logic                   grant;

    // Two passes: sources at or above ptr first, then the wrapped-around ones.
    // The found guard stops later bits from being looked at once a winner exists.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && (i >= int'(ptr_q)) && req_valid[i]) begin
                found  = 1'b1;
                winner = SEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        src_d    = src_q;
        data_d   = data_q;
        can_load = (state_q == EMPTY) || out_ready;
        grant    = can_load && found;
        if (grant) begin
            state_d = FULL;
            data_d  = mux_data;
            src_d   = winner;
            ptr_d   = (winner == SEL_WIDTH'(DEPTH - 1)) ? '0 : winner + 1'b1;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    assign mux_en_n  = ~grant;
    assign mux_sel   = grant ? winner : ptr_q;
    assign req_ready = grant ? (DEPTH'(1) << winner) : '0;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed and randomised bench for mux_rr_arb: a 2-source 4-bit instance and a 3-source 8-bit instance.
module tb_mux_rr_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [1:0] req_valid2, req_ready2;
    logic [0:0] mux_sel2, out_src2;
    logic       mux_en_n2, out_valid2, out_ready2;
    logic [3:0] mux_data2, out_data2;
    logic [3:0] src2_dat [2];

    logic [2:0] req_valid3, req_ready3;
    logic [1:0] mux_sel3, out_src3;
    logic       mux_en_n3, out_valid3, out_ready3;
    logic [7:0] mux_data3, out_data3;
    logic [7:0] src3_dat [3];

    // Behavioural model of the shared mux each arbiter steers.
    assign mux_data2 = mux_en_n2 ? 4'h0 : src2_dat[mux_sel2];
    assign mux_data3 = (mux_en_n3 || (mux_sel3 > 2'd2)) ? 8'h00 : src3_dat[mux_sel3];

    mux_rr_arb #(.BIT_WIDTH(4), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .mux_sel(mux_sel2), .mux_en_n(mux_en_n2), .mux_data(mux_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_src(out_src2)
    );

    mux_rr_arb #(.BIT_WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .mux_sel(mux_sel3), .mux_en_n(mux_en_n3), .mux_data(mux_data3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_src(out_src3)
    );

    task automatic test_reset();
        rst = 1'b1;
        req_valid2 = '0; out_ready2 = 1'b0;
        req_valid3 = '0; out_ready3 = 1'b0;
        src2_dat[0] = 4'hA; src2_dat[1] = 4'h5;
        src3_dat[0] = 8'h30; src3_dat[1] = 8'h31; src3_dat[2] = 8'h32;
        #12;
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid2); end
        checks++; if (out_data2 !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", out_data2); end
        checks++; if (out_src2 !== 1'b0) begin errors++; $display("FAIL reset_out_src got=%0d exp=0", out_src2); end
        checks++; if (req_ready2 !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready2); end
        checks++; if (mux_en_n2 !== 1'b1) begin errors++; $display("FAIL reset_mux_en_n got=%0b exp=1", mux_en_n2); end
        checks++; if (mux_sel2 !== 1'b0) begin errors++; $display("FAIL reset_mux_sel got=%0d exp=0", mux_sel2); end
        checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got=%0b exp=0", out_valid3); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_d;
        req_valid2 = 2'b11; out_ready2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 1) ? 4'h5 : 4'hA;
            #1;
            checks++; if (req_ready2 !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_req_ready[%0d] got=%b", k, req_ready2); end
            checks++; if (mux_en_n2 !== 1'b0) begin errors++; $display("FAIL rr_mux_en_n[%0d] got=%0b exp=0", k, mux_en_n2); end
            @(negedge clk);
            checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL rr_out_valid[%0d] got=%0b exp=1", k, out_valid2); end
            checks++; if (out_data2 !== exp_d) begin errors++; $display("FAIL rr_out_data[%0d] got=%0h exp=%0h", k, out_data2, exp_d); end
            checks++; if (out_src2 !== 1'(k % 2)) begin errors++; $display("FAIL rr_out_src[%0d] got=%0d exp=%0d", k, out_src2, k % 2); end
        end
        req_valid2 = 2'b00;
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL rr_drain_valid got=%0b exp=0", out_valid2); end
        checks++; if (out_data2 !== 4'h5) begin errors++; $display("FAIL rr_drain_hold got=%0h exp=5", out_data2); end
    endtask

    task automatic test_backpressure();
        req_valid2 = 2'b01; out_ready2 = 1'b0;
        #1;
        checks++; if (req_ready2 !== 2'b01) begin errors++; $display("FAIL bp_first_grant got=%b exp=01", req_ready2); end
        @(negedge clk);
        for (int h = 0; h < 3; h++) begin
            #1;
            checks++; if (out_valid2 !== 1'b1 || out_data2 !== 4'hA) begin errors++; $display("FAIL bp_hold[%0d] got valid=%0b data=%0h exp 1/A", h, out_valid2, out_data2); end
            checks++; if (req_ready2 !== 2'b00 || mux_en_n2 !== 1'b1) begin errors++; $display("FAIL bp_blocked[%0d] got ready=%b en_n=%0b exp 00/1", h, req_ready2, mux_en_n2); end
            @(negedge clk);
        end
        req_valid2 = 2'b00; out_ready2 = 1'b1;
        #1;
        checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL bp_still_valid got=%0b exp=1", out_valid2); end
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", out_valid2); end
    endtask

    task automatic test_idle();
        req_valid2 = 2'b10; out_ready2 = 1'b0;
        #1;
        checks++; if (mux_sel2 !== 1'b1 || mux_en_n2 !== 1'b0 || req_ready2 !== 2'b10) begin errors++; $display("FAIL idle_grant1 got sel=%0d en_n=%0b ready=%b exp 1/0/10", mux_sel2, mux_en_n2, req_ready2); end
        @(negedge clk);
        req_valid2 = 2'b00; out_ready2 = 1'b1;
        #1;
        checks++; if (mux_sel2 !== 1'b0 || mux_en_n2 !== 1'b1) begin errors++; $display("FAIL idle_ptr_wrap got sel=%0d en_n=%0b exp 0/1", mux_sel2, mux_en_n2); end
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL idle_drop got=%0b exp=0", out_valid2); end
        checks++; if (out_data2 !== 4'h5 || out_src2 !== 1'b1) begin errors++; $display("FAIL idle_hold got data=%0h src=%0d exp 5/1", out_data2, out_src2); end
        @(negedge clk);
        checks++; if (mux_sel2 !== 1'b0) begin errors++; $display("FAIL idle_ptr_still got=%0d exp=0", mux_sel2); end
        req_valid2 = 2'b10;
        #1;
        checks++; if (mux_sel2 !== 1'b1 || mux_en_n2 !== 1'b0 || req_ready2 !== 2'b10) begin errors++; $display("FAIL idle_grant_src1 got sel=%0d en_n=%0b ready=%b exp 1/0/10", mux_sel2, mux_en_n2, req_ready2); end
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b1 || out_src2 !== 1'b1 || out_data2 !== 4'h5) begin errors++; $display("FAIL idle_out got v=%0b src=%0d data=%0h exp 1/1/5", out_valid2, out_src2, out_data2); end
    endtask

    task automatic test_async_reset();
        src2_dat[0] = 4'h5; req_valid2 = 2'b01; out_ready2 = 1'b1;
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b1 || out_data2 !== 4'h5) begin errors++; $display("FAIL ar_pre got v=%0b data=%0h exp 1/5", out_valid2, out_data2); end
        req_valid2 = 2'b00; out_ready2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid2 !== 1'b0 || out_data2 !== 4'h0 || out_src2 !== 1'b0) begin errors++; $display("FAIL ar_async got v=%0b data=%0h src=%0d exp 0/0/0", out_valid2, out_data2, out_src2); end
        checks++; if (mux_sel2 !== 1'b0) begin errors++; $display("FAIL ar_ptr got=%0d exp=0", mux_sel2); end
        @(negedge clk);
        rst = 1'b0;
        src2_dat[0] = 4'hA; req_valid2 = 2'b11; out_ready2 = 1'b1;
        #1;
        checks++; if (req_ready2 !== 2'b01 || mux_sel2 !== 1'b0) begin errors++; $display("FAIL ar_first_scan got ready=%b sel=%0d exp 01/0", req_ready2, mux_sel2); end
        @(negedge clk);
        checks++; if (out_data2 !== 4'hA || out_src2 !== 1'b0) begin errors++; $display("FAIL ar_first_out got data=%0h src=%0d exp A/0", out_data2, out_src2); end
        req_valid2 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_depth3();
        req_valid3 = 3'b111; out_ready3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (mux_sel3 !== 2'(k % 3)) begin errors++; $display("FAIL d3_sel[%0d] got=%0d exp=%0d", k, mux_sel3, k % 3); end
            @(negedge clk);
            checks++; if (out_src3 !== 2'(k % 3) || out_data3 !== (8'h30 + 8'(k % 3))) begin errors++; $display("FAIL d3_out[%0d] got src=%0d data=%0h exp src=%0d", k, out_src3, out_data3, k % 3); end
        end
        req_valid3 = 3'b000;
        @(negedge clk);
        checks++; if (out_valid3 !== 1'b0 || mux_sel3 !== 2'd0) begin errors++; $display("FAIL d3_idle got v=%0b sel=%0d exp 0/0", out_valid3, mux_sel3); end
    endtask

    task automatic test_random();
        int         seq_tx [3];
        int         seq_rx [3];
        int         waitc  [3];
        logic [2:0] vld;
        logic [1:0] s;
        for (int i = 0; i < 3; i++) begin seq_tx[i] = 0; seq_rx[i] = 0; waitc[i] = 0; end
        vld = '0;
        for (int cyc = 0; cyc < 10000 + 8; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (cyc >= 10000) vld[i] = 1'b0;
                else if (!vld[i]) vld[i] = ($urandom_range(0, 3) != 0);
                else if ($urandom_range(0, 15) == 0) vld[i] = 1'b0;
                if (!vld[i]) waitc[i] = 0;
                src3_dat[i] = {2'(i), 6'(seq_tx[i])};
            end
            req_valid3 = vld;
            out_ready3 = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid3 && out_ready3) begin
                s = out_src3;
                checks++;
                if (s > 2'd2 || out_data3 !== {s, 6'(seq_rx[s])}) begin
                    errors++; $display("FAIL rnd_order cyc=%0d got src=%0d data=%0h", cyc, s, out_data3);
                end
                if (s <= 2'd2) seq_rx[s]++;
            end
            if (req_ready3 != 3'b000) begin
                checks++;
                if (!$onehot(req_ready3) || ((req_ready3 & ~vld) != 3'b000) || (out_valid3 && !out_ready3)) begin
                    errors++; $display("FAIL rnd_grant cyc=%0d got ready=%b valid=%b", cyc, req_ready3, vld);
                end
                for (int i = 0; i < 3; i++) begin
                    if (req_ready3[i]) begin
                        seq_tx[i]++; vld[i] = 1'b0; waitc[i] = 0;
                    end else if (vld[i]) begin
                        waitc[i]++;
                        checks++;
                        if (waitc[i] > 2) begin errors++; $display("FAIL rnd_fair cyc=%0d src=%0d got wait=%0d exp<=2", cyc, i, waitc[i]); end
                    end
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seq_rx[i] !== seq_tx[i] || seq_tx[i] < 100) begin
                errors++; $display("FAIL rnd_count src=%0d got rx=%0d exp tx=%0d", i, seq_rx[i], seq_tx[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_idle();
        test_async_reset();
        test_depth3();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
